// File: rtl/main_control_fsm.sv
// Multicycle main controller: sequences FETCH/DECODE/execute/writeback and drives datapath controls.
// Optional macro MEM_WAIT_EN adds mem_ready and stalls FETCH/MEMREAD/MEMWRITE until memory is done.
module main_control_fsm #(
  parameter int STATE_W    = 4,
  parameter int ALU_CTRL_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            op,
  input  logic [5:0]            funct,
  input  logic [3:0]            rd,
`ifdef MEM_WAIT_EN
  input  logic                  mem_ready,
`endif
  output logic                  pcs,
  output logic                  reg_w,
  output logic                  mem_w,
  output logic [1:0]            flag_w,
  output logic                  no_write,
  output logic                  next_pc,
  output logic                  ir_write,
  output logic                  adr_src,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            result_src,
  output logic [1:0]            imm_src,
  output logic [1:0]            reg_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [STATE_W-1:0]    state
);

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMREAD  = STATE_W'(3),
    MEMWB    = STATE_W'(4),
    MEMWRITE = STATE_W'(5),
    EXECUTER = STATE_W'(6),
    EXECUTEI = STATE_W'(7),
    ALUWB    = STATE_W'(8),
    BRANCH   = STATE_W'(9)
  } state_t;

  state_t state_q, state_d;

  logic       mem_ok;
  logic       alu_op, branch;
  logic       reg_w_c, mem_w_c, next_pc_c, ir_write_c, adr_src_c, alu_src_a_c;
  logic [1:0] alu_src_b_c, result_src_c, flag_w_c, alu_ctl_c;
  logic       no_write_c, is_cmp;

`ifdef MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d      = FETCH;
    alu_op       = 1'b0;
    branch       = 1'b0;
    reg_w_c      = 1'b0;
    mem_w_c      = 1'b0;
    next_pc_c    = 1'b0;
    ir_write_c   = 1'b0;
    adr_src_c    = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'b00;
    result_src_c = 2'b00;
    case (state_q)
      FETCH: begin
        ir_write_c   = mem_ok;
        next_pc_c    = mem_ok;
        alu_src_a_c  = 1'b1;
        alu_src_b_c  = 2'b10;
        result_src_c = 2'b10;
        state_d      = mem_ok ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_a_c  = 1'b1;
        alu_src_b_c  = 2'b10;
        result_src_c = 2'b10;
        case (op)
          2'b00:   state_d = funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: begin
        alu_src_b_c = 2'b01;
        state_d     = funct[0] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_src_c = 1'b1;
        state_d   = mem_ok ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        result_src_c = 2'b01;
        reg_w_c      = 1'b1;
      end
      MEMWRITE: begin
        adr_src_c = 1'b1;
        mem_w_c   = mem_ok;
        state_d   = mem_ok ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        alu_op  = 1'b1;
        state_d = ALUWB;
      end
      EXECUTEI: begin
        alu_src_b_c = 2'b01;
        alu_op      = 1'b1;
        state_d     = ALUWB;
      end
      ALUWB: reg_w_c = 1'b1;
      BRANCH: begin
        alu_src_b_c  = 2'b01;
        result_src_c = 2'b10;
        branch       = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // CMP is decoded from funct so no_write stays asserted into ALUWB.
  assign is_cmp = (funct[4:1] == 4'b1010);

  always_comb begin
    alu_ctl_c  = 2'b00;
    flag_w_c   = 2'b00;
    no_write_c = is_cmp &&
                 (state_q == EXECUTER || state_q == EXECUTEI || state_q == ALUWB);
    if (alu_op) begin
      case (funct[4:1])
        4'b0100: begin alu_ctl_c = 2'b00; flag_w_c = funct[0] ? 2'b11 : 2'b00; end
        4'b0010: begin alu_ctl_c = 2'b01; flag_w_c = funct[0] ? 2'b11 : 2'b00; end
        4'b0000: begin alu_ctl_c = 2'b10; flag_w_c = funct[0] ? 2'b10 : 2'b00; end
        4'b1100: begin alu_ctl_c = 2'b11; flag_w_c = funct[0] ? 2'b10 : 2'b00; end
        4'b1010: begin alu_ctl_c = 2'b01; flag_w_c = 2'b11; end
        default: begin alu_ctl_c = 2'b00; flag_w_c = 2'b00; end
      endcase
    end
  end

  // Everything but state is held at zero while reset is asserted.
  always_comb begin
    pcs         = 1'b0;
    reg_w       = 1'b0;
    mem_w       = 1'b0;
    flag_w      = 2'b00;
    no_write    = 1'b0;
    next_pc     = 1'b0;
    ir_write    = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    imm_src     = 2'b00;
    reg_src     = 2'b00;
    alu_control = '0;
    if (rst) begin
      pcs            = (reg_w_c && rd == 4'hF) || branch;
      reg_w          = reg_w_c;
      mem_w          = mem_w_c;
      flag_w         = flag_w_c;
      no_write       = no_write_c;
      next_pc        = next_pc_c;
      ir_write       = ir_write_c;
      adr_src        = adr_src_c;
      alu_src_a      = alu_src_a_c;
      alu_src_b      = alu_src_b_c;
      result_src     = result_src_c;
      imm_src        = op;
      reg_src        = {op == 2'b01, op == 2'b10};
      alu_control[1:0] = alu_ctl_c;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed table-driven bench for main_control_fsm, plus reset and memory-wait sequences.
module tb_main_control_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] op = 2'b00;
  logic [5:0] funct = 6'b0;
  logic [3:0] rd = 4'h0;
  logic       mem_ready = 1'b1;
  logic       pcs, reg_w, mem_w, no_write, next_pc, ir_write, adr_src, alu_src_a;
  logic [1:0] flag_w, alu_src_b, result_src, imm_src, reg_src, alu_control;
  logic [3:0] state;

  int vec_count  = 0;
  int miss_count = 0;

  always #5 clk = ~clk;

  main_control_fsm #(.STATE_W(4), .ALU_CTRL_W(2)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .rd(rd),
`ifdef MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w), .flag_w(flag_w), .no_write(no_write),
    .next_pc(next_pc), .ir_write(ir_write), .adr_src(adr_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .result_src(result_src), .imm_src(imm_src), .reg_src(reg_src),
    .alu_control(alu_control), .state(state)
  );

  // ctl = {pcs, reg_w, mem_w, flag_w, no_write, next_pc, ir_write, adr_src, alu_src_a, alu_src_b, result_src, alu_control}
  typedef struct {
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic [3:0]  st;
    logic [15:0] ctl;
  } vec_t;

  vec_t vecs[$];

  task automatic applyStimulus(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r);
    op    = o;
    funct = f;
    rd    = r;
  endtask

  // Combinational imm_src/reg_src follow op unless reset is active.
  task automatic checkOutput(input string name, input logic [3:0] exp_st,
                             input logic [15:0] exp_ctl, input logic in_reset);
    logic [15:0] act_ctl;
    logic [23:0] act, exp;
    logic [1:0]  exp_imm, exp_reg;
    act_ctl = {pcs, reg_w, mem_w, flag_w, no_write, next_pc, ir_write, adr_src, alu_src_a,
               alu_src_b, result_src, alu_control};
    exp_imm = in_reset ? 2'b00 : op;
    exp_reg = in_reset ? 2'b00 : {op == 2'b01, op == 2'b10};
    act = {state, act_ctl, imm_src, reg_src};
    exp = {exp_st, exp_ctl, exp_imm, exp_reg};
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got state=%0d ctl=%h imm=%b reg=%b, want state=%0d ctl=%h imm=%b reg=%b",
               name, state, act_ctl, imm_src, reg_src, exp_st, exp_ctl, exp_imm, exp_reg);
    end
  endtask

  task automatic addInstr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                          input logic [3:0] s2, input logic [15:0] c2,
                          input logic [3:0] s3, input logic [15:0] c3,
                          input logic [3:0] s4, input logic [15:0] c4, input int len);
    vecs.push_back('{o, f, r, 4'd0, 16'h0368});
    vecs.push_back('{o, f, r, 4'd1, 16'h0068});
    if (len > 2) vecs.push_back('{o, f, r, s2, c2});
    if (len > 3) vecs.push_back('{o, f, r, s3, c3});
    if (len > 4) vecs.push_back('{o, f, r, s4, c4});
  endtask

  initial begin
    // ADDS imm rd=3, CMP reg, LDR rd=15, STR, B, illegal, ANDS reg, ORR imm rd=15, unknown-S, SUBS
    addInstr(2'b00, 6'b101001, 4'h3, 4'd7, 16'h1810, 4'd8, 16'h4000, 4'd0, 16'h0000, 4);
    addInstr(2'b00, 6'b010101, 4'h2, 4'd6, 16'h1C01, 4'd8, 16'h4400, 4'd0, 16'h0000, 4);
    addInstr(2'b01, 6'b000001, 4'hF, 4'd2, 16'h0010, 4'd3, 16'h0080, 4'd4, 16'hC004, 5);
    addInstr(2'b01, 6'b000000, 4'h4, 4'd2, 16'h0010, 4'd5, 16'h2080, 4'd0, 16'h0000, 4);
    addInstr(2'b10, 6'b000000, 4'h0, 4'd9, 16'h8018, 4'd0, 16'h0000, 4'd0, 16'h0000, 3);
    addInstr(2'b11, 6'b000000, 4'h0, 4'd0, 16'h0000, 4'd0, 16'h0000, 4'd0, 16'h0000, 2);
    addInstr(2'b00, 6'b000001, 4'h5, 4'd6, 16'h1002, 4'd8, 16'h4000, 4'd0, 16'h0000, 4);
    addInstr(2'b00, 6'b111000, 4'hF, 4'd7, 16'h0013, 4'd8, 16'hC000, 4'd0, 16'h0000, 4);
    addInstr(2'b00, 6'b001101, 4'h1, 4'd6, 16'h0000, 4'd8, 16'h4000, 4'd0, 16'h0000, 4);
    addInstr(2'b00, 6'b000101, 4'h6, 4'd6, 16'h1801, 4'd8, 16'h4000, 4'd0, 16'h0000, 4);
    vecs.push_back('{2'b01, 6'b000001, 4'hF, 4'd0, 16'h0368});

    applyStimulus(2'b01, 6'b000001, 4'hF);
    repeat (2) @(negedge clk);
    #1 checkOutput("reset_hold", 4'd0, 16'h0000, 1'b1);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].funct, vecs[i].rd);
      #1 checkOutput($sformatf("vec%0d", i), vecs[i].st, vecs[i].ctl, 1'b0);
      @(negedge clk);
    end

    // Last table row was FETCH of an LDR; now in DECODE, walk into MEMREAD then reset.
    @(negedge clk);
    @(negedge clk);
    #1 checkOutput("ldr_memread", 4'd3, 16'h0080, 1'b0);
    rst = 1'b0;
    #1 checkOutput("reset_mid_memread", 4'd0, 16'h0000, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1 checkOutput("release_fetch", 4'd0, 16'h0368, 1'b0);
    @(negedge clk);
    #1 checkOutput("release_decode", 4'd1, 16'h0068, 1'b0);

`ifdef MEM_WAIT_EN
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(2'b01, 6'b000000, 4'h4);
    mem_ready = 1'b0;
    rst = 1'b1;
    #1 checkOutput("wait_fetch0", 4'd0, 16'h0068, 1'b0);
    @(negedge clk);
    #1 checkOutput("wait_fetch1", 4'd0, 16'h0068, 1'b0);
    mem_ready = 1'b1;
    #1 checkOutput("wait_fetch_ready", 4'd0, 16'h0368, 1'b0);
    @(negedge clk);
    mem_ready = 1'b0;
    #1 checkOutput("wait_decode", 4'd1, 16'h0068, 1'b0);
    @(negedge clk);
    #1 checkOutput("wait_memadr", 4'd2, 16'h0010, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 checkOutput($sformatf("wait_memwrite%0d", k), 4'd5, 16'h0080, 1'b0);
    end
    mem_ready = 1'b1;
    #1 checkOutput("memwrite_ready", 4'd5, 16'h2080, 1'b0);
    @(negedge clk);
    #1 checkOutput("after_memwrite", 4'd0, 16'h0368, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
